serial_frame_rx: RTL

//   Downstream consumer of the bidirectional shift register's serial_out stream.

---
 rtl/serial_frame_rx_pkg.sv | 16 +
 rtl/serial_frame_rx_if.sv | 29 ++
 rtl/serial_frame_rx_shift_core.sv | 47 ++++
 rtl/serial_frame_rx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared state codes and bit-order constants for the serial frame receiver.
// No logic; pure definitions.
// No flow control of its own.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic MODE_LSB_FIRST = 1'b1;
    localparam logic MODE_MSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input strobe plus valid/ready word output of the frame receiver.
// Pure wiring; no latency.
// data_valid is held by the receiver until data_ready is seen.
interface serial_frame_rx_if #(
    parameter int n = 6
);
    logic         mode;
    logic         serial_in;
    logic         bit_valid;
    logic [n-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    // Side that feeds bits and consumes words
    modport master (
        output mode, serial_in, bit_valid, data_ready,
        input  data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    // Receiver side
    modport slave (
        input  mode, serial_in, bit_valid, data_ready,
        output data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_frame_rx_shift_core.sv
// Direction-selectable n-bit shift register with running XOR of its contents.
// One bit enters per clk when shift_en=1; parity is combinational from the register.
// No backpressure; holds when shift_en=0, clr has priority over shift.
module rx_shift_core
    import serial_frame_rx_pkg::*;
#(
    parameter int n = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         sin,
    output logic [n-1:0] data,
    output logic         parity
);

    logic [n-1:0] sr_q, sr_d;

    // Next shift contents: clear, shift right (new bit at MSB) or left (new bit at LSB)
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift_en) begin
            if (dir == MODE_LSB_FIRST) begin
                sr_d = {sin, sr_q[n-1:1]};
            end else begin
                sr_d = {sr_q[n-2:0], sin};
            end
        end
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data   = sr_q;
    assign parity = ^sr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, n data bits, optional even parity, stop bit.
// Word appears on data_out 1 clk after the stop-bit strobe.
// One-deep output; a good frame arriving while full and not ready is dropped (overrun).
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int n         = 6,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    serial_frame_rx_if.slave bus
);

    localparam int CW = $clog2(n + 1);

    rx_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic         par_q, par_d;
    logic [n-1:0] dout_q, dout_d;
    logic         dvld_q, dvld_d;
    logic         perr_q, perr_d;
    logic         ferr_q, ferr_d;
    logic         ovr_q, ovr_d;

    logic         shift_en;
    logic         shift_clr;
    logic [n-1:0] shift_data;
    logic         shift_par;

    rx_shift_core #(.n(n)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (shift_clr),
        .shift_en (shift_en),
        .dir      (mode_q),
        .sin      (bus.serial_in),
        .data     (shift_data),
        .parity   (shift_par)
    );

    // Frame FSM, bit counter and output register next-state; the handshake runs every cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        par_d     = par_q;
        dout_d    = dout_q;
        dvld_d    = dvld_q & ~bus.data_ready;
        perr_d    = perr_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        shift_en  = 1'b0;
        shift_clr = 1'b0;

        if (bus.bit_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.serial_in) begin
                        mode_d    = bus.mode;
                        cnt_d     = '0;
                        par_d     = 1'b0;
                        shift_clr = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(n - 1)) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_d   = bus.serial_in ^ shift_par;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (bus.serial_in) begin
                        if (!dvld_q || bus.data_ready) begin
                            dout_d = shift_data;
                            perr_d = par_q;
                            dvld_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_MSB_FIRST;
            par_q   <= 1'b0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dvld_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
